// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - calculator key-entry sequencer driving one start/done ALU transaction
// Holds operands, operator, result and status for the LCD line writer.
module calc_op_sequencer #(
  parameter int MAX_OPERAND = 99,
  parameter int RES_W       = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic             alu_start,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_err,
  output logic [2:0]       disp_state,
  output logic [2:0]       disp_op,
  output logic             op_set,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMAX    = CNT_W'(TIMEOUT - 1);
  localparam logic [11:0]      MAX_OP  = 12'(MAX_OPERAND);
  localparam logic [RES_W-1:0] MAX_RES = RES_W'(MAX_OPERAND);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t           r_state, w_state;
  logic [7:0]       r_a, w_a, r_b, w_b;
  logic [2:0]       r_op, w_op;
  logic             r_op_set, w_op_set;
  logic [RES_W-1:0] r_result, w_result;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_drain, w_drain;
  logic             r_pend, w_pend;

  logic       w_digit, w_binop, w_fact, w_eq, w_clr;
  logic [3:0] w_d;
  logic [2:0] w_key_op;
  logic [11:0] w_a_ext, w_b_ext;
  logic       w_res_small, w_exec_req, w_do_clear;

  assign w_digit     = key_valid && (key_code <= 5'd9);
  assign w_binop     = key_valid && (key_code >= 5'd10) && (key_code <= 5'd15);
  assign w_fact      = key_valid && (key_code == 5'd16);
  assign w_eq        = key_valid && (key_code == 5'd17);
  assign w_clr       = key_valid && (key_code == 5'd18);
  assign w_d         = key_code[3:0];
  assign w_key_op    = 3'(key_code - 5'd10);
  assign w_a_ext     = ({4'd0, r_a} * 12'd10) + {8'd0, w_d};
  assign w_b_ext     = ({4'd0, r_b} * 12'd10) + {8'd0, w_d};
  assign w_res_small = (r_result <= MAX_RES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_ENTER_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_op_set <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_drain  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_a      <= w_a;
      r_b      <= w_b;
      r_op     <= w_op;
      r_op_set <= w_op_set;
      r_result <= w_result;
      r_cnt    <= w_cnt;
      r_drain  <= w_drain;
      r_pend   <= w_pend;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_a        = r_a;
    w_b        = r_b;
    w_op       = r_op;
    w_op_set   = r_op_set;
    w_result   = r_result;
    w_cnt      = '0;
    w_drain    = r_drain;
    w_pend     = r_pend;
    w_exec_req = 1'b0;
    w_do_clear = 1'b0;

    // Drain swallows the done of an abandoned ALU transaction; it survives clear.
    if (r_drain) begin
      if (alu_done || (r_cnt == TMAX)) begin
        w_drain = 1'b0;
      end else begin
        w_cnt = r_cnt + CNT_W'(1);
      end
    end

    case (r_state)
      S_ENTER_A, S_ENTER_B: begin
        if (w_clr) begin
          w_do_clear = 1'b1;
        end else if (r_pend) begin
          if (!r_drain) begin
            w_pend  = 1'b0;
            w_state = S_EXEC;
          end
        end else if (w_digit) begin
          if (r_state == S_ENTER_A) begin
            if (w_a_ext <= MAX_OP) w_a = w_a_ext[7:0];
          end else begin
            if (w_b_ext <= MAX_OP) w_b = w_b_ext[7:0];
          end
        end else if (w_binop) begin
          w_op     = w_key_op;
          w_op_set = 1'b1;
          if (r_state == S_ENTER_A) begin
            w_b     = '0;
            w_state = S_ENTER_B;
          end
        end else if (w_fact && (r_state == S_ENTER_A)) begin
          w_op       = 3'd6;
          w_op_set   = 1'b1;
          w_b        = '0;
          w_exec_req = 1'b1;
        end else if (w_eq && (r_state == S_ENTER_B)) begin
          w_exec_req = 1'b1;
        end
      end
      S_EXEC: begin
        // Counter measures cycles since alu_start, so it is already 1 in the first WAIT cycle.
        w_state = S_WAIT;
        w_cnt   = CNT_W'(1);
        if (w_clr) begin
          w_do_clear = 1'b1;
          w_drain    = 1'b1;
          w_cnt      = '0;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          if (alu_err) begin
            w_state = S_ERR;
          end else begin
            w_result = alu_result;
            w_state  = S_SHOW;
          end
        end else if (r_cnt == TMAX) begin
          w_state = S_ERR;
        end else if (w_clr) begin
          w_do_clear = 1'b1;
          w_drain    = 1'b1;
          w_cnt      = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_SHOW: begin
        if (w_clr) begin
          w_do_clear = 1'b1;
        end else if (w_digit) begin
          w_a      = {4'd0, w_d};
          w_b      = '0;
          w_op     = '0;
          w_op_set = 1'b0;
          w_state  = S_ENTER_A;
        end else if ((w_binop || w_fact || w_eq) && w_res_small) begin
          w_a = r_result[7:0];
          if (w_binop) begin
            w_op     = w_key_op;
            w_op_set = 1'b1;
            w_b      = '0;
            w_state  = S_ENTER_B;
          end else if (w_fact) begin
            w_op       = 3'd6;
            w_op_set   = 1'b1;
            w_b        = '0;
            w_exec_req = 1'b1;
          end else begin
            w_exec_req = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (w_clr) w_do_clear = 1'b1;
      end
      default: begin
        w_do_clear = 1'b1;
      end
    endcase

    if (w_exec_req) begin
      if (r_drain) w_pend = 1'b1;
      else         w_state = S_EXEC;
    end

    if (w_do_clear) begin
      w_state  = S_ENTER_A;
      w_a      = '0;
      w_b      = '0;
      w_op     = '0;
      w_op_set = 1'b0;
      w_result = '0;
      w_pend   = 1'b0;
    end
  end

  assign alu_start    = (r_state == S_EXEC);
  assign alu_op       = r_op;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign disp_state   = r_state;
  assign disp_op      = r_op;
  assign op_set       = r_op_set;
  assign result       = r_result;
  assign result_valid = (r_state == S_SHOW);
  assign err          = (r_state == S_ERR);
  assign busy         = (r_state == S_EXEC) || (r_state == S_WAIT);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - directed self-checking bench for calc_op_sequencer
module tb_calc_op_sequencer;

  localparam int RES_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_valid;
  logic [4:0]       key_code;
  logic             alu_start;
  logic [2:0]       alu_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_done;
  logic [RES_W-1:0] alu_result;
  logic             alu_err;
  logic [2:0]       disp_state;
  logic [2:0]       disp_op;
  logic             op_set;
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  calc_op_sequencer #(.MAX_OPERAND(99), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_state(disp_state), .disp_op(disp_op), .op_set(op_set),
    .result(result), .result_valid(result_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 5'(k);
    step();
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic alu_reply(input int delay, input int res, input logic e);
    repeat (delay) step();
    alu_done   = 1'b1;
    alu_result = RES_W'(res);
    alu_err    = e;
    step();
    alu_done   = 1'b0;
    alu_result = '0;
    alu_err    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = '0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_state", 32'(disp_state), 0);
    chk("reset_start", 32'(alu_start), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", 32'({op_set, result_valid, err, busy}), 0);

    // 12 + 34 = 46
    press(1); press(2); press(10); press(3); press(4);
    chk("t1_enter_b", 32'(disp_state), 1);
    press(17);
    chk("t1_start", 32'(alu_start), 1);
    chk("t1_a", 32'(alu_a), 12);
    chk("t1_b", 32'(alu_b), 34);
    chk("t1_op", 32'(alu_op), 0);
    chk("t1_busy", 32'(busy), 1);
    step();
    chk("t1_start_pulse", 32'(alu_start), 0);
    chk("t1_wait", 32'(disp_state), 3);
    step(); step();
    chk("t1_not_valid_yet", 32'(result_valid), 0);
    alu_reply(0, 46, 1'b0);
    chk("t1_result", 32'(result), 46);
    chk("t1_valid", 32'(result_valid), 1);
    chk("t1_show", 32'(disp_state), 4);

    // digit saturation, divide-by-zero error, result held
    press(9); press(9); press(9);
    chk("t2_a_sat", 32'(alu_a), 99);
    chk("t2_result_held", 32'(result), 46);
    press(13); press(0); press(17);
    chk("t2_op_div", 32'(alu_op), 3);
    chk("t2_b_zero", 32'(alu_b), 0);
    alu_reply(2, 0, 1'b1);
    chk("t2_err_state", 32'(disp_state), 5);
    chk("t2_err", 32'(err), 1);
    chk("t2_result_unchanged", 32'(result), 46);
    press(5);
    chk("t2_err_ignores_digit", 32'(disp_state), 5);
    press(18);
    chk("t2_clear_state", 32'(disp_state), 0);
    chk("t2_clear_outs", 32'({alu_a, alu_b, 5'(alu_op), 1'(op_set), 1'(err)}), 0);
    chk("t2_clear_result", 32'(result), 0);

    // factorial, then oversize chaining ignored
    press(5); press(16);
    chk("t3_start", 32'(alu_start), 1);
    chk("t3_op", 32'(alu_op), 6);
    chk("t3_b", 32'(alu_b), 0);
    alu_reply(3, 120, 1'b0);
    chk("t3_result", 32'(result), 120);
    press(12);
    chk("t3_chain_ignored", 32'(disp_state), 4);
    press(17);
    chk("t3_repeat_ignored", 32'(alu_start), 0);

    // chaining and repeat
    press(18);
    press(7); press(12); press(6); press(17);
    chk("t4_a", 32'(alu_a), 7);
    chk("t4_op", 32'(alu_op), 2);
    alu_reply(2, 42, 1'b0);
    chk("t4_result", 32'(result), 42);
    press(10);
    chk("t4_chain_state", 32'(disp_state), 1);
    chk("t4_chain_a", 32'(alu_a), 42);
    press(8); press(17);
    chk("t4_chain_start", 32'(alu_start), 1);
    chk("t4_chain_ab", 32'({alu_a, alu_b}), 32'({8'd42, 8'd8}));
    chk("t4_chain_op", 32'(alu_op), 0);
    alu_reply(1, 50, 1'b0);
    press(17);
    chk("t4_repeat_start", 32'(alu_start), 1);
    chk("t4_repeat_ab", 32'({alu_a, alu_b}), 32'({8'd50, 8'd8}));
    alu_reply(1, 58, 1'b0);
    press(3);
    chk("t4_new_entry", 32'({5'(disp_state), 8'(alu_a), 1'(op_set), 1'(result_valid)}), 32'({5'd0, 8'd3, 1'b0, 1'b0}));
    chk("t4_result_held", 32'(result), 58);
    press(0); press(0);
    chk("t4_a_limit", 32'(alu_a), 30);

    // timeout
    press(18);
    press(3); press(11); press(2); press(17);
    chk("t5_start", 32'(alu_start), 1);
    repeat (TIMEOUT - 1) step();
    chk("t5_still_wait", 32'(disp_state), 3);
    step();
    chk("t5_err_state", 32'(disp_state), 5);
    chk("t5_err", 32'(err), 1);

    // clear in WAIT, stale done drained, stalled EXEC
    press(18);
    press(3); press(11); press(2); press(17);
    step();
    press(18);
    chk("t6_clear_wait", 32'({5'(disp_state), 1'(busy)}), 0);
    press(4); press(10); press(1); press(17);
    chk("t6_stalled_state", 32'(disp_state), 1);
    chk("t6_stalled_start", 32'(alu_start), 0);
    step();
    chk("t6_still_stalled", 32'(alu_start), 0);
    alu_reply(0, 999, 1'b1);
    chk("t6_stale_state", 32'(disp_state), 1);
    chk("t6_stale_result", 32'(result), 0);
    for (int i = 0; i < 20 && !alu_start; i++) step();
    chk("t6_restart", 32'(alu_start), 1);
    chk("t6_restart_ab", 32'({alu_a, alu_b}), 32'({8'd4, 8'd1}));
    chk("t6_restart_op", 32'(alu_op), 0);
    alu_reply(2, 5, 1'b0);
    chk("t6_result", 32'(result), 5);

    // reset mid-WAIT, late done ignored
    press(2); press(10); press(3); press(17);
    step();
    chk("t7_wait", 32'(disp_state), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_rst_outs", 32'({alu_a, alu_b, 3'(alu_op), 3'(disp_state), 1'(busy), 1'(alu_start)}), 0);
    chk("t7_rst_result", 32'(result), 0);
    alu_reply(0, 77, 1'b0);
    chk("t7_late_done", 32'({result, 3'(disp_state), 1'(result_valid), 1'(err)}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
